// File: rtl/mnist_pkg.sv
// Shared constants, FSM state encoding and the margin helper for argmax_classifier.
// The margin helper is only referenced when ARGMAX_MARGIN_EN is defined.
package mnist_pkg;

    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;
    localparam int NUM_CLASSES = 10;

    localparam logic [IDX_W-1:0]  LAST_IDX   = 4'd9;
    localparam logic [DATA_W-1:0] SCORE_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MARGIN_MAX = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // best - runner_up in DATA_W+1 bits, clamped to the largest positive score
    function automatic logic [DATA_W-1:0] sat_margin(
        input logic [DATA_W-1:0] best,
        input logic [DATA_W-1:0] runner
    );
        logic [DATA_W:0] diff;
        diff = {best[DATA_W-1], best} - {runner[DATA_W-1], runner};
        if (diff[DATA_W] || diff[DATA_W-1]) begin
            sat_margin = MARGIN_MAX;
        end else begin
            sat_margin = diff[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare of one candidate against the running best.
// Under ARGMAX_MARGIN_EN it also maintains the runner-up score.
module argmax_cmp
    import mnist_pkg::*;
(
    input  logic [DATA_W-1:0] best,
    input  logic [IDX_W-1:0]  best_idx,
    input  logic [DATA_W-1:0] cand,
    input  logic [IDX_W-1:0]  cand_idx,
    output logic [DATA_W-1:0] next_best,
    output logic [IDX_W-1:0]  next_idx
`ifdef ARGMAX_MARGIN_EN
    ,
    input  logic [DATA_W-1:0] runner,
    output logic [DATA_W-1:0] next_runner
`endif
);

    logic win_s;

    // Strictly-greater wins, so ties keep the lower index already held
    always_comb begin
        win_s = ($signed(cand) > $signed(best));
        if (win_s) begin
            next_best = cand;
            next_idx  = cand_idx;
        end else begin
            next_best = best;
            next_idx  = best_idx;
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // Displaced best becomes runner-up; otherwise a larger loser replaces it
    always_comb begin
        if (win_s) begin
            next_runner = best;
        end else if ($signed(cand) > $signed(runner)) begin
            next_runner = cand;
        end else begin
            next_runner = runner;
        end
    end
`endif

endmodule

// File: rtl/argmax_classifier.sv
// Sequential argmax over ten snapshotted signed scores, one class per cycle.
// Optional ARGMAX_MARGIN_EN adds a saturated best-minus-runner-up margin output.
module argmax_classifier
    import mnist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] score0,
    input  logic [DATA_W-1:0] score1,
    input  logic [DATA_W-1:0] score2,
    input  logic [DATA_W-1:0] score3,
    input  logic [DATA_W-1:0] score4,
    input  logic [DATA_W-1:0] score5,
    input  logic [DATA_W-1:0] score6,
    input  logic [DATA_W-1:0] score7,
    input  logic [DATA_W-1:0] score8,
    input  logic [DATA_W-1:0] score9,
    output logic              busy,
    output logic              valid,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] max_score
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W-1:0] margin
`endif
);

    state_t            state_r;
    logic [DATA_W-1:0] score_s [NUM_CLASSES];
    logic [DATA_W-1:0] snap_r  [NUM_CLASSES];
    logic [DATA_W-1:0] best_r;
    logic [IDX_W-1:0]  best_idx_r;
    logic [IDX_W-1:0]  ctr_r;
    logic [DATA_W-1:0] cand_s;
    logic [DATA_W-1:0] next_best_s;
    logic [IDX_W-1:0]  next_idx_s;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] runner_r;
    logic [DATA_W-1:0] next_runner_s;
`endif

    assign score_s[0] = score0;
    assign score_s[1] = score1;
    assign score_s[2] = score2;
    assign score_s[3] = score3;
    assign score_s[4] = score4;
    assign score_s[5] = score5;
    assign score_s[6] = score6;
    assign score_s[7] = score7;
    assign score_s[8] = score8;
    assign score_s[9] = score9;

    // Select the snapshot entry addressed by the scan counter
    always_comb begin
        case (ctr_r)
            4'd1:    cand_s = snap_r[1];
            4'd2:    cand_s = snap_r[2];
            4'd3:    cand_s = snap_r[3];
            4'd4:    cand_s = snap_r[4];
            4'd5:    cand_s = snap_r[5];
            4'd6:    cand_s = snap_r[6];
            4'd7:    cand_s = snap_r[7];
            4'd8:    cand_s = snap_r[8];
            4'd9:    cand_s = snap_r[9];
            default: cand_s = snap_r[0];
        endcase
    end

    argmax_cmp u_cmp (
        .best        (best_r),
        .best_idx    (best_idx_r),
        .cand        (cand_s),
        .cand_idx    (ctr_r),
        .next_best   (next_best_s),
        .next_idx    (next_idx_s)
`ifdef ARGMAX_MARGIN_EN
        ,
        .runner      (runner_r),
        .next_runner (next_runner_s)
`endif
    );

    // Scan FSM: snapshot on start, fold one class per edge, publish at ctr=9
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            valid      <= 1'b0;
            class_idx  <= '0;
            max_score  <= '0;
            best_r     <= '0;
            best_idx_r <= '0;
            ctr_r      <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap_r[i] <= '0;
            end
`ifdef ARGMAX_MARGIN_EN
            runner_r   <= '0;
            margin     <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_CLASSES; i++) begin
                            snap_r[i] <= score_s[i];
                        end
                        best_r     <= score_s[0];
                        best_idx_r <= 4'd0;
                        ctr_r      <= 4'd1;
                        busy       <= 1'b1;
                        state_r    <= SCAN;
`ifdef ARGMAX_MARGIN_EN
                        runner_r   <= SCORE_MIN;
`endif
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SCAN: begin
                    best_r     <= next_best_s;
                    best_idx_r <= next_idx_s;
`ifdef ARGMAX_MARGIN_EN
                    runner_r   <= next_runner_s;
`endif
                    if (ctr_r == LAST_IDX) begin
                        class_idx <= next_idx_s;
                        max_score <= next_best_s;
`ifdef ARGMAX_MARGIN_EN
                        margin    <= sat_margin(next_best_s, next_runner_s);
`endif
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        ctr_r     <= 4'd0;
                        state_r   <= IDLE;
                    end else begin
                        ctr_r <= ctr_r + 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed, table-driven bench for argmax_classifier (margin checks under ARGMAX_MARGIN_EN).
module tb_argmax_classifier;

    logic              clk;
    logic              reset;
    logic              start;
    logic [9:0][31:0]  scores;
    logic              busy;
    logic              valid;
    logic [3:0]        class_idx;
    logic [31:0]       max_score;
`ifdef ARGMAX_MARGIN_EN
    logic [31:0]       margin;
`endif

    int total;
    int bad;

    typedef struct {
        logic [9:0][31:0] s;
        logic [3:0]       exp_idx;
        logic [31:0]      exp_max;
        logic [31:0]      exp_margin;
    } vec_t;

    vec_t vecs [8];

    argmax_classifier dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .score0    (scores[0]),
        .score1    (scores[1]),
        .score2    (scores[2]),
        .score3    (scores[3]),
        .score4    (scores[4]),
        .score5    (scores[5]),
        .score6    (scores[6]),
        .score7    (scores[7]),
        .score8    (scores[8]),
        .score9    (scores[9]),
        .busy      (busy),
        .valid     (valid),
        .class_idx (class_idx),
        .max_score (max_score)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin    (margin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Drive scores and a one-cycle start; returns at the first negedge after the start edge
    task automatic start_scan(input logic [9:0][31:0] s);
        scores = s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called at the first negedge after the start edge; returns at the negedge where valid is seen
    task automatic finish_scan(input string name, input logic [3:0] ei, input logic [31:0] em,
                               input logic [31:0] emg);
        int cyc;
        int busy_err;
        cyc = 1;
        busy_err = 0;
        while (!valid && cyc < 20) begin
            if (busy !== 1'b1) busy_err++;
            @(negedge clk);
            cyc++;
        end
        chk({name, "_latency"}, 32'(cyc), 32'd10);
        chk({name, "_busy_scan"}, 32'(busy_err), 32'd0);
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_idx"}, {28'd0, class_idx}, {28'd0, ei});
        chk({name, "_max"}, max_score, em);
`ifdef ARGMAX_MARGIN_EN
        chk({name, "_margin"}, margin, emg);
`else
        if (emg === 32'hxxxx_xxxx) $display("note: margin unused");
`endif
    endtask

    initial begin
        logic [9:0][31:0] s;
        int vcount;
        int early;
        total = 0;
        bad   = 0;

        // v0: score_k = k
        for (int k = 0; k < 10; k++) s[k] = 32'(k);
        vecs[0] = '{s, 4'd9, 32'd9, 32'd1};
        // v1: clear winner at index 0
        for (int k = 0; k < 10; k++) s[k] = -32'sd20;
        s[0] = 32'd500;
        vecs[1] = '{s, 4'd0, 32'd500, 32'd520};
        // v2: tie at 3 and 7, lowest index wins
        for (int k = 0; k < 10; k++) s[k] = 32'd0;
        s[3] = 32'd1000;
        s[7] = 32'd1000;
        vecs[2] = '{s, 4'd3, 32'd1000, 32'd0};
        // v3: negatives, winner at last index
        for (int k = 0; k < 10; k++) s[k] = -32'sd6;
        s[9] = -32'sd5;
        vecs[3] = '{s, 4'd9, 32'hFFFF_FFFB, 32'd1};
        // v4: extreme values, margin saturation
        for (int k = 0; k < 10; k++) s[k] = 32'h8000_0000;
        s[0] = 32'h7FFF_FFFF;
        vecs[4] = '{s, 4'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        // v5: all equal
        for (int k = 0; k < 10; k++) s[k] = 32'd42;
        vecs[5] = '{s, 4'd0, 32'd42, 32'd0};
        // v6: descending with a peak at 6
        for (int k = 0; k < 10; k++) s[k] = 32'(9 - k);
        s[6] = 32'd100;
        vecs[6] = '{s, 4'd6, 32'd100, 32'd91};
        // v7: large positive late, a negative in between
        for (int k = 0; k < 10; k++) s[k] = 32'd0;
        s[2] = 32'hFFFF_FFFF;
        s[8] = 32'h7FFF_FFFE;
        vecs[7] = '{s, 4'd8, 32'h7FFF_FFFE, 32'h7FFF_FFFE};

        reset  = 1'b1;
        start  = 1'b0;
        scores = '0;
        #1;
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_idx",   {28'd0, class_idx}, 32'd0);
        chk("rst_max",   max_score, 32'd0);
`ifdef ARGMAX_MARGIN_EN
        chk("rst_margin", margin, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            start_scan(vecs[v].s);
            finish_scan($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_max, vecs[v].exp_margin);
            @(negedge clk);
            chk($sformatf("vec%0d_valid_pulse", v), {31'd0, valid}, 32'd0);
            chk($sformatf("vec%0d_idx_hold", v), {28'd0, class_idx}, {28'd0, vecs[v].exp_idx});
        end

        // Snapshot: inputs change right after the start edge
        for (int k = 0; k < 10; k++) s[k] = -32'sd1000;
        s[5] = -32'sd1;
        start_scan(s);
        scores = '0;
        finish_scan("snapshot", 4'd5, 32'hFFFF_FFFF, 32'd999);
        @(negedge clk);

        // Starts while busy are ignored; start on the valid cycle launches a new scan
        start_scan(vecs[0].s);
        early = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            start = (cyc == 3 || cyc == 6);
            if (valid) early++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("restart_no_early_valid", 32'(early), 32'd0);
        chk("restart_valid", {31'd0, valid}, 32'd1);
        chk("restart_idx", {28'd0, class_idx}, 32'd9);
        scores = vecs[1].s;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("b2b_valid_low", {31'd0, valid}, 32'd0);
        finish_scan("b2b", 4'd0, 32'd500, 32'd520);
        @(negedge clk);

        // Reset in scan cycle 4 clears outputs at once and suppresses valid
        start_scan(vecs[6].s);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy",  {31'd0, busy}, 32'd0);
        chk("midrst_idx",   {28'd0, class_idx}, 32'd0);
        chk("midrst_max",   max_score, 32'd0);
`ifdef ARGMAX_MARGIN_EN
        chk("midrst_margin", margin, 32'd0);
`endif
        @(negedge clk);
        reset  = 1'b0;
        vcount = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (valid || busy) vcount++;
            @(negedge clk);
        end
        chk("midrst_no_valid", 32'(vcount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
